// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone B4 arbiter sharing one slave port.
// A master owns the bus for its whole cyc; release hands over next edge.
module wb_arbiter #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int num_masters = 2
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic [num_masters*aw-1:0]      wbm_adr_i,
    input  logic [num_masters*dw-1:0]      wbm_dat_i,
    input  logic [num_masters*(dw/8)-1:0]  wbm_sel_i,
    input  logic [num_masters-1:0]         wbm_we_i,
    input  logic [num_masters-1:0]         wbm_cyc_i,
    input  logic [num_masters-1:0]         wbm_stb_i,
    input  logic [num_masters*3-1:0]       wbm_cti_i,
    input  logic [num_masters*2-1:0]       wbm_bte_i,
    output logic [dw-1:0]                  wbm_dat_o,
    output logic [num_masters-1:0]         wbm_ack_o,
    output logic [num_masters-1:0]         wbm_err_o,
    output logic [num_masters-1:0]         wbm_rty_o,
    output logic [aw-1:0]                  wbs_adr_o,
    output logic [dw-1:0]                  wbs_dat_o,
    output logic [dw/8-1:0]                wbs_sel_o,
    output logic                           wbs_we_o,
    output logic                           wbs_cyc_o,
    output logic                           wbs_stb_o,
    output logic [2:0]                     wbs_cti_o,
    output logic [1:0]                     wbs_bte_o,
    input  logic [dw-1:0]                  wbs_dat_i,
    input  logic                           wbs_ack_i,
    input  logic                           wbs_err_i,
    input  logic                           wbs_rty_i
);
    localparam int GW = (num_masters > 1) ? $clog2(num_masters) : 1;
    localparam int SW = dw / 8;

    logic                   r_active;
    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          w_next;
    logic                   w_any;
    logic                   w_own_cyc;
    logic [num_masters-1:0] w_sel;
    int                     w_g;

    assign w_g       = int'(r_grant);
    assign w_own_cyc = wbm_cyc_i[r_grant];

    // Scan from the farthest slot inward so the nearest requester
    // after the current grant is the one left standing.
    always_comb begin
        w_next = r_grant;
        w_any  = 1'b0;
        for (int k = num_masters; k >= 1; k--) begin
            if (wbm_cyc_i[(w_g + k) % num_masters]) begin
                w_next = GW'((w_g + k) % num_masters);
                w_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_active <= 1'b0;
            r_grant  <= GW'(num_masters - 1);
        end else if (r_active && w_own_cyc) begin
            r_active <= 1'b1;
        end else if (w_any) begin
            r_active <= 1'b1;
            r_grant  <= w_next;
        end else begin
            r_active <= 1'b0;
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < num_masters; i++) begin
            w_sel[i] = r_active && (r_grant == GW'(i));
        end
    end

    assign wbs_cyc_o = r_active & w_own_cyc;
    assign wbs_stb_o = wbs_cyc_o & wbm_stb_i[r_grant];
    assign wbs_adr_o = wbm_adr_i[w_g*aw +: aw];
    assign wbs_dat_o = wbm_dat_i[w_g*dw +: dw];
    assign wbs_sel_o = wbm_sel_i[w_g*SW +: SW];
    assign wbs_we_o  = wbm_we_i[r_grant];
    assign wbs_cti_o = wbm_cti_i[w_g*3 +: 3];
    assign wbs_bte_o = wbm_bte_i[w_g*2 +: 2];

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = w_sel & {num_masters{wbs_ack_i}};
    assign wbm_err_o = w_sel & {num_masters{wbs_err_i}};
    assign wbm_rty_o = w_sel & {num_masters{wbs_rty_i}};
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus a randomized 4-master regression
// against a round-robin ownership model and a per-master shadow memory.
module tb_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;

    logic [N*AW-1:0]     wbm_adr_i;
    logic [N*DW-1:0]     wbm_dat_i;
    logic [N*(DW/8)-1:0] wbm_sel_i;
    logic [N-1:0]        wbm_we_i;
    logic [N-1:0]        wbm_cyc_i;
    logic [N-1:0]        wbm_stb_i;
    logic [N*3-1:0]      wbm_cti_i;
    logic [N*2-1:0]      wbm_bte_i;
    logic [DW-1:0]       wbm_dat_o;
    logic [N-1:0]        wbm_ack_o;
    logic [N-1:0]        wbm_err_o;
    logic [N-1:0]        wbm_rty_o;
    logic [AW-1:0]       wbs_adr_o;
    logic [DW-1:0]       wbs_dat_o;
    logic [DW/8-1:0]     wbs_sel_o;
    logic                wbs_we_o;
    logic                wbs_cyc_o;
    logic                wbs_stb_o;
    logic [2:0]          wbs_cti_o;
    logic [1:0]          wbs_bte_o;
    logic [DW-1:0]       wbs_dat_i;
    logic                wbs_ack_i;
    logic                wbs_err_i;
    logic                wbs_rty_i;

    logic [AW-1:0]   m_adr [N];
    logic [DW-1:0]   m_dat [N];
    logic [DW/8-1:0] m_sel [N];
    logic            m_we  [N];
    logic            m_cyc [N];
    logic            m_stb [N];
    logic [2:0]      m_cti [N];
    logic [1:0]      m_bte [N];

    int n_tests = 0;
    int n_fail  = 0;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_pack
            assign wbm_adr_i[g*AW +: AW]         = m_adr[g];
            assign wbm_dat_i[g*DW +: DW]         = m_dat[g];
            assign wbm_sel_i[g*(DW/8) +: (DW/8)] = m_sel[g];
            assign wbm_we_i[g]                   = m_we[g];
            assign wbm_cyc_i[g]                  = m_cyc[g];
            assign wbm_stb_i[g]                  = m_stb[g];
            assign wbm_cti_i[g*3 +: 3]           = m_cti[g];
            assign wbm_bte_i[g*2 +: 2]           = m_bte[g];
        end
    endgenerate

    wb_arbiter #(.dw(DW), .aw(AW), .num_masters(N)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_cti_i (wbm_cti_i),
        .wbm_bte_i (wbm_bte_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            m_adr[i] = '0;
            m_dat[i] = '0;
            m_sel[i] = '0;
            m_we[i]  = 1'b0;
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
            m_cti[i] = 3'b000;
            m_bte[i] = 2'b00;
        end
        wbs_dat_i = '0;
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
    endtask

    task automatic set_m(input int i, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[i] = cyc;
        m_stb[i] = cyc;
        m_we[i]  = we;
        m_adr[i] = adr;
        m_dat[i] = dat;
        m_sel[i] = 4'hF;
        m_cti[i] = 3'b000;
        m_bte[i] = 2'b00;
    endtask

    task automatic run_random();
        bit           act = 1'b0;
        int           gr = N - 1;
        int           waitg [N];
        bit           busy [N];
        int           gap [N];
        int           widx [N];
        bit           pend = 1'b0;
        int           dly = 0;
        int           done = 0;
        int           cycles = 0;
        logic [N-1:0] ackv = '0;
        logic [31:0]  smem [64];
        logic [31:0]  shadow [64];
        for (int i = 0; i < 64; i++) begin
            smem[i]   = '0;
            shadow[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            waitg[i] = 0;
            busy[i]  = 1'b0;
            gap[i]   = int'($urandom_range(1, 3));
            widx[i]  = i * 16;
        end
        rst = 1'b1;
        clear_all();
        tick();
        rst = 1'b0;
        while (done < 1000 && cycles < 40000) begin
            logic [N-1:0] cv;
            logic [N-1:0] ev;
            bit           exp_cyc;
            @(posedge clk);
            cycles++;
            for (int i = 0; i < N; i++) cv[i] = m_cyc[i];
            // Owner keeps the bus while cyc holds; else nearest requester wins
            if (!(act && cv[gr])) begin
                if (cv != '0) begin
                    int win  = 0;
                    int best = N;
                    for (int j = 0; j < N; j++) begin
                        if (cv[j] && ((j - gr - 1 + N) % N) < best) begin
                            best = (j - gr - 1 + N) % N;
                            win  = j;
                        end
                    end
                    for (int j = 0; j < N; j++)
                        if (cv[j] && j != win) waitg[j]++;
                    chk("starve", 64'(waitg[win] <= N - 1), 64'h1);
                    waitg[win] = 0;
                    gr  = win;
                    act = 1'b1;
                end else begin
                    act = 1'b0;
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (ackv[i]) begin
                    if (m_we[i]) shadow[widx[i]] = m_dat[i];
                    busy[i]  = 1'b0;
                    m_cyc[i] = 1'b0;
                    m_stb[i] = 1'b0;
                    gap[i]   = int'($urandom_range(1, 4));
                    done++;
                end else if (!busy[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else begin
                        busy[i]  = 1'b1;
                        widx[i]  = i * 16 + int'($urandom_range(0, 15));
                        m_adr[i] = 32'(i * 4096 + (widx[i] % 16) * 4);
                        m_we[i]  = 1'($urandom_range(0, 1));
                        m_dat[i] = $urandom;
                        m_sel[i] = 4'hF;
                        m_cyc[i] = 1'b1;
                        m_stb[i] = 1'b1;
                        waitg[i] = 0;
                    end
                end
            end
            exp_cyc   = act && m_cyc[gr];
            wbs_ack_i = 1'b0;
            wbs_dat_i = $urandom;
            if (exp_cyc) begin
                if (!pend) begin
                    pend = 1'b1;
                    dly  = int'($urandom_range(0, 2));
                end
                if (dly == 0) begin
                    wbs_ack_i = 1'b1;
                    pend      = 1'b0;
                    if (!m_we[gr]) wbs_dat_i = smem[widx[gr]];
                end else begin
                    dly--;
                end
            end
            #1;
            ev = '0;
            if (wbs_ack_i && act) ev[gr] = 1'b1;
            chk("r_cyc", 64'(wbs_cyc_o), 64'(exp_cyc));
            chk("r_stb", 64'(wbs_stb_o), 64'(exp_cyc));
            if (exp_cyc) begin
                chk("r_adr", 64'(wbs_adr_o), 64'(m_adr[gr]));
                chk("r_we", 64'(wbs_we_o), 64'(m_we[gr]));
                if (m_we[gr]) chk("r_wdat", 64'(wbs_dat_o), 64'(m_dat[gr]));
            end
            chk("r_ack", 64'(wbm_ack_o), 64'(ev));
            if (ev != '0 && !m_we[gr])
                chk("r_rdat", 64'(wbm_dat_o), 64'(shadow[widx[gr]]));
            if (ev != '0 && m_we[gr]) smem[widx[gr]] = wbs_dat_o;
            ackv = ev;
        end
        chk("r_done", 64'(done), 64'd1000);
        clear_all();
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        tick();
        tick();
        chk("rst_cyc", 64'(wbs_cyc_o), 64'h0);
        chk("rst_ack", 64'(wbm_ack_o), 64'h0);
        rst = 1'b0;

        // single write from master 0
        set_m(0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        #1;
        chk("t1_lat", 64'(wbs_cyc_o), 64'h0);
        tick();
        chk("t1_cyc", 64'(wbs_cyc_o), 64'h1);
        chk("t1_adr", 64'(wbs_adr_o), 64'h100);
        chk("t1_we", 64'(wbs_we_o), 64'h1);
        chk("t1_dat", 64'(wbs_dat_o), 64'hDEADBEEF);
        chk("t1_ack0", 64'(wbm_ack_o), 64'h0);
        wbs_ack_i = 1'b1;
        #1;
        chk("t1_ack", 64'(wbm_ack_o), 64'h1);
        tick();
        wbs_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_rel", 64'(wbs_cyc_o), 64'h0);
        chk("t1_noack", 64'(wbm_ack_o), 64'h0);
        tick();

        // simultaneous requests and round-robin order
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h200, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        chk("t2_cyc", 64'(wbs_cyc_o), 64'h1);
        chk("t2_first", 64'(wbs_adr_o), 64'h200);
        wbs_ack_i = 1'b1;
        #1;
        chk("t2_ack0", 64'(wbm_ack_o), 64'h1);
        tick();
        wbs_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t2_gap", 64'(wbs_cyc_o), 64'h0);
        tick();
        chk("t2_hcyc", 64'(wbs_cyc_o), 64'h1);
        chk("t2_hand", 64'(wbs_adr_o), 64'h300);
        wbs_ack_i = 1'b1;
        #1;
        chk("t2_ack1", 64'(wbm_ack_o), 64'h2);
        tick();
        wbs_ack_i = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        set_m(0, 1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        chk("t2_solo", 64'(wbs_adr_o), 64'h200);
        wbs_ack_i = 1'b1;
        tick();
        wbs_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        set_m(0, 1'b1, 1'b0, 32'h200, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        chk("t2_rr", 64'(wbs_adr_o), 64'h300);
        wbs_ack_i = 1'b1;
        #1;
        chk("t2_rr_ack", 64'(wbm_ack_o), 64'h2);
        tick();
        wbs_ack_i = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t2_rr2_cyc", 64'(wbs_cyc_o), 64'h1);
        chk("t2_rr2", 64'(wbs_adr_o), 64'h200);
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // 4-beat burst from master 1 while master 0 waits
        set_m(1, 1'b1, 1'b1, 32'h400, 32'hA0);
        m_bte[1] = 2'b01;
        tick();
        set_m(0, 1'b1, 1'b0, 32'h500, 32'h0);
        for (int b = 0; b < 4; b++) begin
            m_adr[1] = 32'h400 + 32'(b * 4);
            m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
            wbs_ack_i = 1'b1;
            #1;
            chk("t3_ack", 64'(wbm_ack_o), 64'h2);
            chk("t3_adr", 64'(wbs_adr_o), 64'h400 + 64'(b * 4));
            chk("t3_cti", 64'(wbs_cti_o), (b == 3) ? 64'h7 : 64'h2);
            chk("t3_bte", 64'(wbs_bte_o), 64'h1);
            tick();
        end
        wbs_ack_i = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t3_rel", 64'(wbs_cyc_o), 64'h0);
        tick();
        chk("t3_m0cyc", 64'(wbs_cyc_o), 64'h1);
        chk("t3_m0", 64'(wbs_adr_o), 64'h500);

        // err, rty and read data go only to the owner
        set_m(1, 1'b1, 1'b0, 32'h600, 32'h0);
        wbs_err_i = 1'b1;
        #1;
        chk("t4_err", 64'(wbm_err_o), 64'h1);
        chk("t4_err_ack", 64'(wbm_ack_o), 64'h0);
        tick();
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b1;
        #1;
        chk("t4_rty", 64'(wbm_rty_o), 64'h1);
        chk("t4_err0", 64'(wbm_err_o), 64'h0);
        tick();
        wbs_rty_i = 1'b0;
        wbs_dat_i = 32'h12345678;
        wbs_ack_i = 1'b1;
        #1;
        chk("t4_rdat", 64'(wbm_dat_o), 64'h12345678);
        chk("t4_ack", 64'(wbm_ack_o), 64'h1);
        tick();
        wbs_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // reset while master 0 owns the bus
        set_m(0, 1'b1, 1'b1, 32'h700, 32'h55);
        tick();
        chk("t5_cyc", 64'(wbs_cyc_o), 64'h1);
        rst = 1'b1;
        set_m(1, 1'b1, 1'b0, 32'h800, 32'h0);
        tick();
        chk("t5_rst", 64'(wbs_cyc_o), 64'h0);
        wbs_ack_i = 1'b1;
        #1;
        chk("t5_rst_ack", 64'(wbm_ack_o), 64'h0);
        wbs_ack_i = 1'b0;
        rst = 1'b0;
        tick();
        chk("t5_recyc", 64'(wbs_cyc_o), 64'h1);
        chk("t5_regrant", 64'(wbs_adr_o), 64'h700);
        clear_all();
        tick();

        run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin Wishbone B4 bus arbiter. It lets NUM_MASTERS masters share a single slave port. The block sits in the interconnect between CPU/DMA masters and a shared slave, or in front of a wb_mux. One master owns the bus for the whole of its cycle (cyc high). Ownership then passes fairly to the next requesting master.

## Interface
Parameters:
- dw, 32, data width
- aw, 32, address width
- num_masters, 2, number of master ports (≥1); grant index width = max(1, clog2(num_masters))

Ports (master-side buses are packed, master i occupies slice i):
- wb_clk_i  in  1  clock; all state changes on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbm_adr_i  in  num_masters*aw  master addresses
- wbm_dat_i  in  num_masters*dw  master write data
- wbm_sel_i  in  num_masters*dw/8  byte selects
- wbm_we_i  in  num_masters  write enables
- wbm_cyc_i  in  num_masters  cycle requests
- wbm_stb_i  in  num_masters  strobes
- wbm_cti_i  in  num_masters*3  cycle type ids
- wbm_bte_i  in  num_masters*2  burst type ext
- wbm_dat_o  out  dw  read data, broadcast to all masters
- wbm_ack_o / wbm_err_o / wbm_rty_o  out  num_masters  responses, one-hot to granted master
- wbs_adr_o  out  aw; wbs_dat_o  out  dw; wbs_sel_o  out  dw/8; wbs_we_o  out  1; wbs_cyc_o  out  1; wbs_stb_o  out  1; wbs_cti_o  out  3; wbs_bte_o  out  2: slave request
- wbs_dat_i  in  dw; wbs_ack_i / wbs_err_i / wbs_rty_i  in  1: slave response

## Operation
- State registers:
  - active (bus owned), 1 bit.
  - grant, the index of the owning master.
  - Reset: active=0, grant=num_masters-1, so master 0 has first priority.
- Arbitration on each edge, when not reset:
  - Hold case: if active=1 and wbm_cyc_i[grant]=1, hold grant and active.
  - Select case: otherwise, if any wbm_cyc_i bit is set, pick the first requester scanning grant+1, grant+2, … mod num_masters, ending with grant itself. Load it into grant and set active=1.
  - Idle case: otherwise active=0 and grant is unchanged.
- Request path (combinational):
  - wbs_cyc_o = active & wbm_cyc_i[grant].
  - wbs_stb_o = wbs_cyc_o & wbm_stb_i[grant].
  - adr/dat/sel/we/cti/bte are muxed from slice grant; these values are don't-care when wbs_cyc_o=0.
- Response path (combinational):
  - wbm_ack_o[i] = wbs_ack_i & active & (grant==i); err and rty are formed the same way.
  - wbm_dat_o = wbs_dat_i, unconditionally.
  - Non-granted masters never see ack, err or rty.
- No transaction is modified. Bursts (cti/bte) pass through unchanged. Ownership is never pre-empted while the owner holds cyc.
- num_masters=1 degenerates to a pass-through with one cycle of grant latency.

## Timing
- Grant latency: master asserts cyc in cycle N on an idle bus → wbs_cyc_o high in cycle N+1.
- Owner release: when the owner drops cyc, wbs_cyc_o falls in the same cycle (combinational).
- Handover at that edge: if another master is requesting at that edge, it is granted and its cyc appears at the slave in the next cycle. There are no dead cycles beyond that one.
- Simultaneous requests: the round-robin order after the last grant decides. Losers keep waiting, with ack held 0.
- Owner drops cyc and re-requests immediately: it is re-granted only if no other master is requesting.
- Reset mid-transfer: at the reset edge active→0, so wbs_cyc_o=0 and all wbm_*_o acks are 0 from the next cycle on. Reset has priority over all arbitration.
- The block is purely combinational from slave response to master response, so it adds zero latency to ack.

## Test plan
- Reset, then master 0 writes adr 0x100 dat 0xDEADBEEF: wbs_cyc_o rises one cycle after wbm_cyc_i[0]. Slave sees adr 0x100, we=1. wbm_ack_o=2'b01 on slave ack. wbm_ack_o[1] stays 0 throughout.
- Both masters raise cyc in the same cycle after reset: master 0 is granted first. When it drops cyc, master 1 owns the slave on the next cycle. A second simultaneous request then grants master 1 before master 0 (round robin).
- Master 1 runs a 4-beat incrementing burst (cti 3'b010, then 3'b111) while master 0 requests: all 4 acks go to master 1, and master 0 is granted only after master 1 deasserts cyc.
- Slave returns err and rty: these appear only on the granted master's bit. Read data 0x12345678 appears on wbm_dat_o.
- Assert wb_rst_i while master 0's cycle is active: wbs_cyc_o is 0 the cycle after. The arbiter then re-grants master 0 (priority restored) once reset is released.
- Random regression, num_masters=4, 1000 transactions each with random data and delays, checked against a memory model:
  - every write is readable back by its master;
  - no master starves beyond num_masters-1 intervening grants.
